// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
//   coin_tbl_t   : packed per-denomination value table, entry [0] is the smallest coin
//   state_e      : controller state encoding
//   coin_value() : table lookup of a coin value
//   params_ok()  : elaboration-time legality check of a parameter set
package vend_pkg;

  localparam int unsigned MAX_COIN  = 8;
  localparam int unsigned VAL_W     = 8;
  localparam int unsigned MAX_SEL_W = $clog2(MAX_COIN);

  typedef logic [MAX_COIN-1:0][VAL_W-1:0] coin_tbl_t;

  // Default denominations {1,2,5}; unused upper entries are zero.
  localparam coin_tbl_t DEF_COIN_VAL = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd2, 8'd1};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_e;

  function automatic logic [VAL_W-1:0] coin_value(input coin_tbl_t tbl,
                                                  input logic [MAX_SEL_W-1:0] sel);
    return tbl[sel];
  endfunction

  // Ascending values, smallest coin worth 1 (greedy termination), price within the ceiling,
  // ceiling representable in the credit register.
  function automatic bit params_ok(input coin_tbl_t tbl, input int unsigned num_coin,
                                   input int unsigned credit_w, input int unsigned price,
                                   input int unsigned max_credit);
    bit ok;
    ok = (num_coin >= 1) && (num_coin <= MAX_COIN) && (tbl[0] == VAL_W'(1)) &&
         (price >= 1) && (price <= max_credit) && (credit_w < 32) &&
         (max_credit < (32'd1 << credit_w));
    for (int unsigned i = 1; i < MAX_COIN; i++) begin
      if (i < num_coin && tbl[MAX_SEL_W'(i)] <= tbl[MAX_SEL_W'(i - 1)]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest denomination whose value does not exceed the credit.
//   credit_i    in  CREDIT_W  credit still to be returned
//   chg_sel_c_o out SEL_W     chosen denomination index (0 when nothing fits)
//   found_c_o   out 1         some denomination fits (credit > 0)
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int unsigned NUM_COIN = 3,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned SEL_W    = 2,
  parameter coin_tbl_t   COIN_VAL = DEF_COIN_VAL
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [SEL_W-1:0]    chg_sel_c_o,
  output logic                found_c_o
);

  // Ascending table: the last fitting entry in index order is the largest.
  always_comb begin
    chg_sel_c_o = '0;
    found_c_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_COIN; i++) begin
      if (32'(coin_value(COIN_VAL, MAX_SEL_W'(i))) <= 32'(credit_i)) begin
        chg_sel_c_o = SEL_W'(i);
        found_c_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: collects coins, vends at PRICE, then pays change
// (or refunds on cancel) one coin per dispenser handshake, largest coin first.
//   clk, reset       clock / synchronous active-high reset
//   coin_valid_i     coin strobe, coin_sel_i its denomination index
//   cancel_i         refund request (COLLECT only)
//   coin_accept_o    pulse: coin credited;  coin_reject_o pulse: coin returned
//   vend_o           pulse: release one product
//   chg_valid_o      change coin request, chg_sel_o its index, chg_ready_i dispenser ack
//   credit_o         current credit;  busy_o high in VEND or CHANGE
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int unsigned NUM_COIN   = 3,
  parameter int unsigned CREDIT_W   = 4,
  parameter coin_tbl_t   COIN_VAL   = DEF_COIN_VAL,
  parameter int unsigned PRICE      = 7,
  parameter int unsigned MAX_CREDIT = 15,
  localparam int unsigned SEL_W     = (NUM_COIN > 1) ? $clog2(NUM_COIN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid_i,
  input  logic [SEL_W-1:0]    coin_sel_i,
  input  logic                cancel_i,
  output logic                coin_accept_o,
  output logic                coin_reject_o,
  output logic                vend_o,
  output logic                chg_valid_o,
  output logic [SEL_W-1:0]    chg_sel_o,
  input  logic                chg_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o
);

  if (!params_ok(COIN_VAL, NUM_COIN, CREDIT_W, PRICE, MAX_CREDIT)) begin : g_bad_params
    $error("vend_ctrl_param: illegal NUM_COIN/COIN_VAL/PRICE/MAX_CREDIT/CREDIT_W");
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_accept_q, coin_accept_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_q, vend_d;
  logic                chg_valid_q, chg_valid_d;
  logic [SEL_W-1:0]    chg_sel_q, chg_sel_d;
  logic                busy_q, busy_d;
  logic [SEL_W-1:0]    pick_sel;
  logic                pick_found;
  logic [31:0]         sum_c;

  // Picker looks at the next credit so chg_sel is registered alongside the credit it serves.
  vend_change_sel #(
    .NUM_COIN (NUM_COIN),
    .CREDIT_W (CREDIT_W),
    .SEL_W    (SEL_W),
    .COIN_VAL (COIN_VAL)
  ) u_change_sel (
    .credit_i    (credit_d),
    .chg_sel_c_o (pick_sel),
    .found_c_o   (pick_found)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      credit_q      <= '0;
      coin_accept_q <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_q        <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_sel_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_accept_q <= coin_accept_d;
      coin_reject_q <= coin_reject_d;
      vend_q        <= vend_d;
      chg_valid_q   <= chg_valid_d;
      chg_sel_q     <= chg_sel_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, credit and pulse logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_accept_d = 1'b0;
    coin_reject_d = 1'b0;
    vend_d        = 1'b0;
    // Wide sum so an oversize coin can never wrap below the ceiling.
    sum_c = 32'(credit_q) + 32'(coin_value(COIN_VAL, MAX_SEL_W'(coin_sel_i)));

    unique case (state_q)
      COLLECT: begin
        if (32'(credit_q) >= PRICE) begin
          state_d       = VEND;
          credit_d      = credit_q - CREDIT_W'(PRICE);
          vend_d        = 1'b1;
          coin_reject_d = coin_valid_i;
        end else if (cancel_i && credit_q != '0) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid_i;
        end else if (coin_valid_i) begin
          if (32'(coin_sel_i) >= NUM_COIN || sum_c > MAX_CREDIT) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d      = CREDIT_W'(sum_c);
            coin_accept_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_d = coin_valid_i;
        state_d       = (credit_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_reject_d = coin_valid_i;
        if (chg_valid_q && chg_ready_i) begin
          credit_d = credit_q - CREDIT_W'(coin_value(COIN_VAL, MAX_SEL_W'(chg_sel_q)));
          if (credit_d == '0) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    chg_valid_d = (state_d == CHANGE) && pick_found;
    chg_sel_d   = (state_d == CHANGE) ? pick_sel : '0;
    busy_d      = (state_d != COLLECT);
  end

  assign coin_accept_o = coin_accept_q;
  assign coin_reject_o = coin_reject_q;
  assign vend_o        = vend_q;
  assign chg_valid_o   = chg_valid_q;
  assign chg_sel_o     = chg_sel_q;
  assign credit_o      = credit_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param: dut A uses defaults (PRICE 7, MAX 15),
// dut B uses PRICE 8, MAX_CREDIT 8. Expected output events are queued when stimulus
// is driven and compared in order as the DUTs emit them.
module tb_vend_ctrl_param;
  import vend_pkg::*;

  localparam int unsigned K_ACC  = 1;
  localparam int unsigned K_REJ  = 2;
  localparam int unsigned K_VEND = 3;
  localparam int unsigned K_CHG  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_coin_valid, a_cancel, a_chg_ready;
  logic [1:0] a_coin_sel, a_chg_sel;
  logic       a_accept, a_reject, a_vend, a_chg_valid, a_busy;
  logic [3:0] a_credit;
  logic       b_coin_valid, b_cancel, b_chg_ready;
  logic [1:0] b_coin_sel, b_chg_sel;
  logic       b_accept, b_reject, b_vend, b_chg_valid, b_busy;
  logic [3:0] b_credit;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [19:0] sb_q[$];

  vend_ctrl_param u_dut_a (
    .clk(clk), .reset(reset), .coin_valid_i(a_coin_valid), .coin_sel_i(a_coin_sel),
    .cancel_i(a_cancel), .coin_accept_o(a_accept), .coin_reject_o(a_reject),
    .vend_o(a_vend), .chg_valid_o(a_chg_valid), .chg_sel_o(a_chg_sel),
    .chg_ready_i(a_chg_ready), .credit_o(a_credit), .busy_o(a_busy)
  );

  vend_ctrl_param #(.PRICE(8), .MAX_CREDIT(8)) u_dut_b (
    .clk(clk), .reset(reset), .coin_valid_i(b_coin_valid), .coin_sel_i(b_coin_sel),
    .cancel_i(b_cancel), .coin_accept_o(b_accept), .coin_reject_o(b_reject),
    .vend_o(b_vend), .chg_valid_o(b_chg_valid), .chg_sel_o(b_chg_sel),
    .chg_ready_i(b_chg_ready), .credit_o(b_credit), .busy_o(b_busy)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [19:0] ev(input int unsigned dut, input int unsigned kind,
                                     input int unsigned sel, input int unsigned cred);
    return {4'(dut), 4'(kind), 4'(sel), 8'(cred)};
  endfunction

  task automatic expect_ev(input int unsigned dut, input int unsigned kind,
                           input int unsigned sel, input int unsigned cred);
    sb_q.push_back(ev(dut, kind, sel, cred));
  endtask

  task automatic observe(input int unsigned dut, input int unsigned kind,
                         input int unsigned sel, input int unsigned cred);
    logic [19:0] got;
    logic [19:0] exp;
    got = ev(dut, kind, sel, cred);
    if (sb_q.size() == 0) begin
      check("sb_unexpected", 32'(got), 0);
    end else begin
      exp = sb_q.pop_front();
      check("sb_event", 32'(got), 32'(exp));
    end
  endtask

  // Monitor: fixed order accept, reject, vend, change handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_accept) observe(0, K_ACC, 0, 32'(a_credit));
      if (a_reject) observe(0, K_REJ, 0, 32'(a_credit));
      if (a_vend)   observe(0, K_VEND, 0, 32'(a_credit));
      if (a_chg_valid && a_chg_ready) observe(0, K_CHG, 32'(a_chg_sel), 32'(a_credit));
      if (b_accept) observe(1, K_ACC, 0, 32'(b_credit));
      if (b_reject) observe(1, K_REJ, 0, 32'(b_credit));
      if (b_vend)   observe(1, K_VEND, 0, 32'(b_credit));
      if (b_chg_valid && b_chg_ready) observe(1, K_CHG, 32'(b_chg_sel), 32'(b_credit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int unsigned dut, input int unsigned sel);
    if (dut == 0) begin a_coin_valid = 1'b1; a_coin_sel = 2'(sel); end
    else          begin b_coin_valid = 1'b1; b_coin_sel = 2'(sel); end
    tick();
    a_coin_valid = 1'b0;
    b_coin_valid = 1'b0;
  endtask

  task automatic cancel(input int unsigned dut);
    if (dut == 0) a_cancel = 1'b1;
    else          b_cancel = 1'b1;
    tick();
    a_cancel = 1'b0;
    b_cancel = 1'b0;
  endtask

  // Wait until every queued event has appeared and both controllers are idle.
  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while ((sb_q.size() != 0 || a_busy || b_busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 60), 1);
    tick();
    check({tag, "_credit_a"}, 32'(a_credit), 0);
    check({tag, "_credit_b"}, 32'(b_credit), 0);
    check({tag, "_chg_valid"}, 32'(a_chg_valid | b_chg_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    a_coin_valid = 1'b0; a_coin_sel = '0; a_cancel = 1'b0; a_chg_ready = 1'b1;
    b_coin_valid = 1'b0; b_coin_sel = '0; b_cancel = 1'b0; b_chg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", 32'(a_credit), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_chg_valid", 32'(a_chg_valid), 0);
    check("rst_chg_sel", 32'(a_chg_sel), 0);
    check("rst_vend", 32'(a_vend), 0);
    reset = 1'b0;
    tick();

    // 1: 5 + 2 = 7, vend exactly one cycle after credit shows 7
    expect_ev(0, K_ACC, 0, 5); expect_ev(0, K_ACC, 0, 7); expect_ev(0, K_VEND, 0, 0);
    coin(0, 2); coin(0, 1);
    check("t1_credit7", 32'(a_credit), 7);
    check("t1_no_early_vend", 32'(a_vend), 0);
    tick();
    check("t1_vend_latency", 32'(a_vend), 1);
    wait_idle("t1");

    // 1b: coin arriving while credit already >= PRICE is rejected, vend still happens
    expect_ev(0, K_ACC, 0, 5); expect_ev(0, K_ACC, 0, 7);
    expect_ev(0, K_REJ, 0, 0); expect_ev(0, K_VEND, 0, 0);
    coin(0, 2); coin(0, 1); coin(0, 0);
    wait_idle("t1b");

    // out-of-range denomination index
    expect_ev(0, K_REJ, 0, 0);
    coin(0, 3);
    wait_idle("t_badsel");

    // 2: 10 -> vend, change 3 = 2 + 1
    expect_ev(0, K_ACC, 0, 5); expect_ev(0, K_ACC, 0, 10); expect_ev(0, K_VEND, 0, 3);
    expect_ev(0, K_CHG, 1, 3); expect_ev(0, K_CHG, 0, 1);
    coin(0, 2); coin(0, 2);
    wait_idle("t2");

    // 3: refund of 2 via cancel, then cancel at zero credit is ignored
    expect_ev(0, K_ACC, 0, 2); expect_ev(0, K_CHG, 1, 2);
    coin(0, 1); cancel(0);
    wait_idle("t3");
    cancel(0); tick();
    check("t3_cancel_zero_busy", 32'(a_busy), 0);

    // 4: dispenser stalls 4 cycles; outputs hold, coin rejected, credit untouched
    a_chg_ready = 1'b0;
    expect_ev(0, K_ACC, 0, 5); expect_ev(0, K_ACC, 0, 10); expect_ev(0, K_VEND, 0, 3);
    coin(0, 2); coin(0, 2); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", 32'(a_chg_valid), 1);
      check("t4_hold_sel", 32'(a_chg_sel), 1);
      check("t4_hold_credit", 32'(a_credit), 3);
      if (i == 1) begin
        expect_ev(0, K_REJ, 0, 3);
        coin(0, 0);
      end else begin
        tick();
      end
    end
    expect_ev(0, K_CHG, 1, 3); expect_ev(0, K_CHG, 0, 1);
    a_chg_ready = 1'b1;
    wait_idle("t4");

    // 5: ceiling 8: 6 + 5 rejected; coin + cancel -> cancel wins; refund 6 = 5 + 1
    expect_ev(1, K_ACC, 0, 5); expect_ev(1, K_ACC, 0, 6);
    coin(1, 2); coin(1, 0);
    expect_ev(1, K_REJ, 0, 6);
    coin(1, 2);
    check("t5_sat_credit", 32'(b_credit), 6);
    expect_ev(1, K_REJ, 0, 6); expect_ev(1, K_CHG, 2, 6); expect_ev(1, K_CHG, 0, 1);
    b_coin_valid = 1'b1; b_coin_sel = 2'd0; b_cancel = 1'b1;
    tick();
    b_coin_valid = 1'b0; b_cancel = 1'b0;
    wait_idle("t5");

    // 5b: credit exactly at the ceiling is accepted and vends
    expect_ev(1, K_ACC, 0, 5); expect_ev(1, K_ACC, 0, 7); expect_ev(1, K_ACC, 0, 8);
    expect_ev(1, K_VEND, 0, 0);
    coin(1, 2); coin(1, 1); coin(1, 0);
    wait_idle("t5b");

    // 6: reset in CHANGE with credit 3 discards it
    a_chg_ready = 1'b0;
    expect_ev(0, K_ACC, 0, 5); expect_ev(0, K_ACC, 0, 10); expect_ev(0, K_VEND, 0, 3);
    coin(0, 2); coin(0, 2); tick(); tick();
    check("t6_pre_credit", 32'(a_credit), 3);
    check("t6_pre_valid", 32'(a_chg_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_credit", 32'(a_credit), 0);
    check("t6_chg_valid", 32'(a_chg_valid), 0);
    check("t6_busy", 32'(a_busy), 0);
    check("t6_vend", 32'(a_vend), 0);
    check("t6_sb_empty", 32'(sb_q.size()), 0);
    a_chg_ready = 1'b1;
    expect_ev(0, K_ACC, 0, 1); expect_ev(0, K_CHG, 0, 1);
    coin(0, 0); cancel(0);
    wait_idle("t6_after");

    check("final_sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
